// File: rtl/conv_window_sequencer_if.sv
// Pixel-stream, window-handshake and status signals between the 3x3 window sequencer and its
// neighbours. The master side is the environment; the slave side is the sequencer.
interface conv_window_sequencer_if #(
    parameter int unsigned COL_W = 10,
    parameter int unsigned ROW_W = 9
);
    logic             frame_start;
    logic             pixel_valid;
    logic             pixel_ready;
    logic             shift_en;
    logic             conv_ready;
    logic             window_valid;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             line_end;
    logic             frame_done;
    logic             busy;
    logic             restart_err;

    modport master (
        output frame_start, pixel_valid, conv_ready,
        input  pixel_ready, shift_en, window_valid, win_row, win_col,
        input  line_end, frame_done, busy, restart_err
    );

    modport slave (
        input  frame_start, pixel_valid, conv_ready,
        output pixel_ready, shift_en, window_valid, win_row, win_col,
        output line_end, frame_done, busy, restart_err
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Tracks pixel position for the 3x3 line-buffer, drives its shift strobe and hands each
// complete window to the convolution unit over a valid/ready handshake.
module conv_window_sequencer #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned COL_W      = 10,
    parameter int unsigned ROW_W      = 9
) (
    input logic                    clk,
    input logic                    rst,
    conv_window_sequencer_if.slave bus
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {StIdle, StFill, StStream, StFlush, StDone} state_e;

    state_e           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             win_valid_q;
    logic [ROW_W-1:0] win_row_q;
    logic [COL_W-1:0] win_col_q;
    logic             line_end_q;
    logic             frame_done_q;
    logic             restart_err_q;

    logic pixel_ready;
    logic accept;
    logic consume;
    logic last_col;
    logic last_row;
    logic make_win;
    logic restart;

    // STREAM only admits a pixel when it cannot overwrite an unconsumed window.
    always_comb begin
        pixel_ready = 1'b0;
        unique case (state_q)
            StFill:   pixel_ready = 1'b1;
            StStream: pixel_ready = !win_valid_q || bus.conv_ready;
            default:  pixel_ready = 1'b0;
        endcase
    end

    assign accept   = bus.pixel_valid && pixel_ready;
    assign consume  = win_valid_q && bus.conv_ready;
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign make_win = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign restart  = bus.frame_start &&
                      (state_q == StFill || state_q == StStream || state_q == StFlush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            win_valid_q   <= 1'b0;
            win_row_q     <= '0;
            win_col_q     <= '0;
            line_end_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            restart_err_q <= 1'b0;
        end else begin
            line_end_q    <= accept && last_col;
            frame_done_q  <= 1'b0;
            restart_err_q <= 1'b0;

            if (accept) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end

            // A window generated in the consuming cycle replaces the old one without a bubble.
            if (make_win) begin
                win_valid_q <= 1'b1;
                win_row_q   <= row_q - ROW_W'(1);
                win_col_q   <= col_q - COL_W'(1);
            end else if (consume) begin
                win_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.frame_start) state_q <= StFill;
                end
                StFill: begin
                    if (accept && row_q == ROW_W'(2) && col_q == COL_W'(1)) state_q <= StStream;
                end
                StStream: begin
                    if (accept && last_row && last_col) state_q <= StFlush;
                end
                StFlush: begin
                    if (!win_valid_q || bus.conv_ready) begin
                        state_q      <= StDone;
                        frame_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (bus.frame_start) begin
                col_q   <= '0;
                row_q   <= '0;
                state_q <= StFill;
                if (restart) begin
                    restart_err_q <= 1'b1;
                    win_valid_q   <= 1'b0;
                    line_end_q    <= 1'b0;
                    frame_done_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.pixel_ready  = pixel_ready;
    assign bus.shift_en     = accept;
    assign bus.window_valid = win_valid_q;
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
    assign bus.line_end     = line_end_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.restart_err  = restart_err_q;
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for the 3x3 window sequencer on a 4x4 image: directed scenarios plus random frames,
// checked against a raster-order window list and pixel-index arithmetic.
module tb_conv_window_sequencer;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 2;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.COL_W(CW), .ROW_W(RW)) bus ();

    conv_window_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state, updated once per cycle at the falling edge.
    int   exp_r[$];
    int   exp_c[$];
    int   cyc_cnt = 0;
    int   acc_cnt = 0;
    int   last_acc_cyc = 0;
    int   fd_cyc = 0;
    int   n_shift = 0, n_le = 0, n_fd = 0, n_win = 0, n_re = 0;
    int   b_shift, b_le, b_fd, b_win;
    logic prev_valid = 1'b0, prev_cons = 1'b0, prev_pend = 1'b0;
    int   prev_r, prev_c;
    logic exp_le = 1'b0, exp_re = 1'b0;

    function automatic void build_windows();
        exp_r.delete();
        exp_c.delete();
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        end
    endfunction

    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            acc_cnt = 0;
            exp_r.delete();
            exp_c.delete();
            prev_valid = 1'b0;
            prev_cons  = 1'b0;
            prev_pend  = 1'b0;
            exp_le     = 1'b0;
            exp_re     = 1'b0;
        end else begin
            chk("shift_en", bus.shift_en, bus.pixel_valid & bus.pixel_ready);
            chk("line_end", bus.line_end, exp_le);
            chk("restart_err", bus.restart_err, exp_re);
            if (prev_pend) begin
                chk("stall_valid", bus.window_valid, 1);
                chk("stall_row", bus.win_row, prev_r);
                chk("stall_col", bus.win_col, prev_c);
            end
            if (bus.window_valid && !bus.conv_ready) chk("bp_pixel_ready", bus.pixel_ready, 0);
            if (bus.window_valid && (!prev_valid || prev_cons)) begin
                chk("win_expected", int'(exp_r.size() > 0), 1);
                if (exp_r.size() > 0)
                    chk("win_latency", acc_cnt, (exp_r[0] + 1) * W + exp_c[0] + 2);
            end
            if (bus.window_valid && bus.conv_ready) begin
                chk("win_consumable", int'(exp_r.size() > 0), 1);
                if (exp_r.size() > 0) begin
                    chk("win_row", bus.win_row, exp_r[0]);
                    chk("win_col", bus.win_col, exp_c[0]);
                    void'(exp_r.pop_front());
                    void'(exp_c.pop_front());
                end
                n_win++;
            end
            if (bus.frame_done) begin
                chk("fd_windows_left", exp_r.size(), 0);
                chk("fd_accepts", acc_cnt, W * H);
                fd_cyc = cyc_cnt;
                n_fd++;
            end
            if (bus.line_end) n_le++;
            if (bus.restart_err) n_re++;
            exp_le = bus.shift_en && (acc_cnt % W == W - 1);
            if (bus.shift_en) begin
                if (acc_cnt == W * H - 1) last_acc_cyc = cyc_cnt;
                acc_cnt++;
                n_shift++;
            end
            exp_re     = bus.frame_start && bus.busy && !bus.frame_done;
            prev_valid = bus.window_valid;
            prev_cons  = bus.window_valid && bus.conv_ready;
            prev_pend  = bus.window_valid && !bus.conv_ready;
            prev_r     = bus.win_row;
            prev_c     = bus.win_col;
            if (bus.frame_start) begin
                acc_cnt = 0;
                build_windows();
                if (bus.busy && !bus.frame_done) begin
                    prev_valid = 1'b0;
                    prev_pend  = 1'b0;
                end
            end
        end
    end

    task automatic frame_begin();
        b_shift = n_shift;
        b_le    = n_le;
        b_fd    = n_fd;
        b_win   = n_win;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // pv_mode: 0 always valid, 1 toggling, 2 random; cr_mode: 0 always ready, 2 random.
    task automatic frame_run(input int pv_mode, input int cr_mode);
        int cyc = 0;
        while (n_fd == b_fd && cyc < 600) begin
            if (pv_mode == 0)      bus.pixel_valid = 1'b1;
            else if (pv_mode == 1) bus.pixel_valid = cyc[0];
            else                   bus.pixel_valid = ($urandom_range(0, 3) != 0);
            bus.conv_ready = (cr_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        bus.pixel_valid = 1'b0;
        bus.conv_ready  = 1'b1;
    endtask

    task automatic frame_end_check(input string tag);
        chk({tag, "_shifts"}, n_shift - b_shift, W * H);
        chk({tag, "_line_ends"}, n_le - b_le, H);
        chk({tag, "_frame_done"}, n_fd - b_fd, 1);
        chk({tag, "_windows"}, n_win - b_win, (W - 2) * (H - 2));
        chk({tag, "_windows_left"}, exp_r.size(), 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_window_valid"}, bus.window_valid, 0);
        chk({tag, "_win_row"}, bus.win_row, 0);
        chk({tag, "_win_col"}, bus.win_col, 0);
        chk({tag, "_line_end"}, bus.line_end, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_restart_err"}, bus.restart_err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_pixel_ready"}, bus.pixel_ready, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.conv_ready  = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Basic frame, continuous input, always-ready consumer.
        bus.conv_ready = 1'b1;
        frame_begin();
        chk("basic_busy", bus.busy, 1);
        chk("basic_fill_ready", bus.pixel_ready, 1);
        frame_run(0, 0);
        frame_end_check("basic");
        chk("basic_fd_latency", fd_cyc - last_acc_cyc, 2);

        // Backpressure on the first window.
        frame_begin();
        bus.pixel_valid = 1'b1;
        bus.conv_ready  = 1'b1;
        cyc = 0;
        while (!bus.window_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp_first_window", bus.window_valid, 1);
        bus.conv_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", bus.window_valid, 1);
            chk("bp_row", bus.win_row, 1);
            chk("bp_col", bus.win_col, 1);
            chk("bp_ready", bus.pixel_ready, 0);
            chk("bp_shift", bus.shift_en, 0);
            tick();
        end
        bus.conv_ready = 1'b1;
        frame_run(0, 0);
        frame_end_check("bp");

        // Gapped input.
        frame_begin();
        frame_run(1, 0);
        frame_end_check("gap");

        // Restart after 9 accepted pixels.
        frame_begin();
        bus.pixel_valid = 1'b1;
        bus.conv_ready  = 1'b1;
        cyc = 0;
        while (acc_cnt < 9 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("rs_accepts", acc_cnt, 9);
        frame_begin();
        chk("rs_err", bus.restart_err, 1);
        chk("rs_window_valid", bus.window_valid, 0);
        chk("rs_busy", bus.busy, 1);
        tick();
        chk("rs_err_pulse", bus.restart_err, 0);
        frame_run(0, 0);
        frame_end_check("rs");
        chk("rs_err_count", n_re, 1);

        // Reset mid-STREAM with a window pending.
        frame_begin();
        bus.pixel_valid = 1'b1;
        bus.conv_ready  = 1'b1;
        cyc = 0;
        while (!bus.window_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        bus.conv_ready = 1'b0;
        tick();
        tick();
        chk("rst_pending", bus.window_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_ready", bus.pixel_ready, 0);
            chk("midrst_shift", bus.shift_en, 0);
        end
        bus.pixel_valid = 1'b0;
        bus.conv_ready  = 1'b1;
        tick();

        // Final window stalled in FLUSH.
        frame_begin();
        bus.pixel_valid = 1'b1;
        bus.conv_ready  = 1'b1;
        cyc = 0;
        while (acc_cnt < W * H && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("fs_accepts", acc_cnt, W * H);
        bus.conv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fs_valid", bus.window_valid, 1);
            chk("fs_row", bus.win_row, 2);
            chk("fs_col", bus.win_col, 2);
            chk("fs_busy", bus.busy, 1);
            chk("fs_no_done", bus.frame_done, 0);
            tick();
        end
        bus.conv_ready = 1'b1;
        tick();
        chk("fs_done", bus.frame_done, 1);
        tick();
        bus.pixel_valid = 1'b0;
        frame_end_check("fs");

        // Random frames.
        for (int f = 0; f < 6; f++) begin
            frame_begin();
            frame_run(2, 2);
            frame_end_check("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Controls the 3x3 line-buffer/window datapath that feeds the convolution stage.
- Tracks the row/column position of the incoming pixel stream and generates the line-buffer shift enable.
- Declares when a complete 3x3 window exists and hands each window to the convolution unit with a valid/ready handshake.
- Applies backpressure upstream when the convolution unit stalls, and reports line and frame boundaries.

Parameters:
- IMG_WIDTH, 640, pixels per line (minimum 3)
- IMG_HEIGHT, 480, lines per frame (minimum 3)
- COL_W, 10, column counter width (must satisfy 2^COL_W >= IMG_WIDTH)
- ROW_W, 9, row counter width (must satisfy 2^ROW_W >= IMG_HEIGHT)

Ports:
- clk, input, 1, system clock; all logic on rising edge
- rst, input, 1, synchronous, active-high reset
- frame_start, input, 1, single-cycle pulse that arms the sequencer for a new frame
- pixel_valid, input, 1, upstream pixel present this cycle
- pixel_ready, output, 1, sequencer can accept a pixel this cycle
- shift_en, output, 1, line-buffer shift strobe; combinational, equals pixel_valid AND pixel_ready
- conv_ready, input, 1, convolution unit accepts the current window
- window_valid, output, 1, a complete 3x3 window is present in the line buffer
- win_row, output, ROW_W, centre row of the presented window
- win_col, output, COL_W, centre column of the presented window
- line_end, output, 1, pulse: last pixel of a line was accepted
- frame_done, output, 1, pulse: frame fully processed
- busy, output, 1, state is not IDLE
- restart_err, output, 1, pulse: frame_start arrived while busy

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; col=0, row=0.
  - All registered outputs are 0: window_valid, win_row, win_col, line_end, frame_done, restart_err.
  - Reset mid-frame discards all progress; no pulses are emitted.
- States: IDLE, FILL, STREAM, FLUSH, DONE.
- IDLE:
  - pixel_ready=0.
  - frame_start moves the state to FILL and clears col/row.
- FILL:
  - pixel_ready=1 unconditionally.
  - Moves to STREAM on acceptance of pixel (row=2, col=1), i.e. one pixel before the first complete window.
- STREAM:
  - pixel_ready = NOT window_valid OR conv_ready.
  - Moves to FLUSH on acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- FLUSH:
  - pixel_ready=0.
  - Holds until no window is outstanding: either window_valid=0, or window_valid AND conv_ready in this cycle. Then moves to DONE.
- DONE:
  - frame_done=1 for exactly one cycle, then the state returns to IDLE.
- Acceptance (pixel_valid AND pixel_ready):
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - line_end=1 on the next cycle for that acceptance (registered).
  - row wraps to 0 after the last line.
- Window generation:
  - Applies when an accepted pixel has row>=2 and col>=2.
  - Next cycle: window_valid=1, win_row=row-1, win_col=col-1.
  - Border centres (row 0, row IMG_HEIGHT-1, col 0, col IMG_WIDTH-1) never produce windows.
  - Latency from accepting the completing pixel to window_valid is 1 cycle.
  - Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Handshake:
  - window_valid, win_row and win_col stay stable until conv_ready=1.
  - If a new window is generated in the same cycle that the current one is consumed, the new window replaces it with no bubble.
  - window_valid drops when the window is consumed and no new window is generated.
  - Because of the STREAM pixel_ready rule, an unconsumed window is never overwritten.
- frame_start while busy:
  - restart_err=1 for one cycle.
  - col/row are cleared and the state goes to FILL.
  - window_valid is cleared and the outstanding window is dropped.
  - frame_done is not emitted.
- frame_start in DONE is treated as in IDLE: frame_done still pulses and the next state is FILL.
- pixel_valid in IDLE/FLUSH/DONE is ignored: no shift, no counter change.
- busy = (state != IDLE), combinational.

Test Plan:
- Basic frame, IMG_WIDTH=4, IMG_HEIGHT=4, conv_ready=1, pixel_valid=1 continuously after frame_start:
  - Exactly 4 windows, centres (1,1),(1,2),(2,1),(2,2).
  - First window_valid on the cycle after the 11th accepted pixel.
  - line_end pulses 4 times.
  - frame_done pulses once, 1 cycle after the FLUSH exit condition is met; busy then drops.
- Backpressure, same geometry, conv_ready=0 held for 5 cycles once the first window appears:
  - window_valid stays 1 with win_row=1, win_col=1 stable.
  - pixel_ready=0 and shift_en=0 throughout the stall.
  - After release, all 4 windows are delivered in order with none lost or duplicated.
- Gapped input, pixel_valid toggled 1/0 each cycle:
  - Counters advance only on acceptances.
  - Same 4 window centres as the basic frame; shift_en asserted exactly 16 times.
- Restart, frame_start pulsed after 9 accepted pixels:
  - restart_err=1 for one cycle; window_valid=0.
  - A full subsequent frame yields exactly 4 windows and one frame_done.
- Reset, rst=1 for 1 cycle mid-STREAM with a window pending:
  - Next cycle all outputs are 0 and busy=0.
  - pixel_ready=0 until the next frame_start.
- Final window stall, conv_ready=0 when the last pixel is accepted:
  - State holds in FLUSH with window_valid=1, win_row=2, win_col=2.
  - frame_done pulses only after conv_ready=1.
